// File: rtl/synch_fifo_gen2_if.sv
// synch_fifo_gen2_if
// Handshake and status bundle for synch_fifo_gen2.
//   master : producer/consumer side; drives fifo_wren, fifo_wrdata, fifo_rden,
//            fifo_err_clr and observes data, flags, counts and error flags.
//   slave  : the FIFO itself (opposite directions).
// Counts are FIFO_PTR+1 bits wide so they can represent FIFO_DEPTH exactly.
interface synch_fifo_gen2_if #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
);
  localparam int FIFO_PTR = $clog2(FIFO_DEPTH);

  logic                  fifo_wren;
  logic [FIFO_WIDTH-1:0] fifo_wrdata;
  logic                  fifo_rden;
  logic                  fifo_err_clr;
  logic [FIFO_WIDTH-1:0] fifo_rddata;
  logic                  fifo_rdvalid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_afull;
  logic                  fifo_aempty;
  logic [FIFO_PTR:0]     fifo_data_avail;
  logic [FIFO_PTR:0]     fifo_room_avail;
  logic                  fifo_ovf;
  logic                  fifo_udf;

  modport master (
    output fifo_wren, fifo_wrdata, fifo_rden, fifo_err_clr,
    input  fifo_rddata, fifo_rdvalid, fifo_full, fifo_empty, fifo_afull,
           fifo_aempty, fifo_data_avail, fifo_room_avail, fifo_ovf, fifo_udf
  );

  modport slave (
    input  fifo_wren, fifo_wrdata, fifo_rden, fifo_err_clr,
    output fifo_rddata, fifo_rdvalid, fifo_full, fifo_empty, fifo_afull,
           fifo_aempty, fifo_data_avail, fifo_room_avail, fifo_ovf, fifo_udf
  );
endinterface

// File: rtl/synch_fifo_gen2.sv
// synch_fifo_gen2
// Single-clock FIFO with arbitrary depth, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a flop-array storage.
// Ports:
//   fifo_clk : clock, all logic on the rising edge
//   rst      : synchronous active-high reset (contents discarded, array kept)
//   fifo_if  : synch_fifo_gen2_if.slave bundle (write/read requests, data,
//              full/empty/afull/aempty flags, occupancy/room counts, ovf/udf)
// Build option:
//   SYNCH_FIFO_FWFT_EN defined   -> first-word-fall-through read port
//                                   (head word shown combinationally, rden pops)
//   SYNCH_FIFO_FWFT_EN undefined -> registered read port, data one cycle after
//                                   the accepting edge with a one-cycle rdvalid
module synch_fifo_gen2 #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int AFULL_LVL  = FIFO_DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input logic              fifo_clk,
  input logic              rst,
  synch_fifo_gen2_if.slave fifo_if
);
  localparam int FIFO_PTR = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = FIFO_PTR + 1;

  localparam logic [FIFO_PTR-1:0] PTR_LAST  = FIFO_PTR'(FIFO_DEPTH - 1);
  localparam logic [FIFO_PTR-1:0] PTR_ZERO  = {FIFO_PTR{1'b0}};
  localparam logic [FIFO_PTR-1:0] PTR_ONE   = FIFO_PTR'(1);
  localparam logic [CNT_W-1:0]    CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_DEPTH = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]    CNT_AFULL = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0]    CNT_AEMPT = CNT_W'(AEMPTY_LVL);

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [FIFO_PTR-1:0] ptr_inc(input logic [FIFO_PTR-1:0] p);
    if (p == PTR_LAST) begin
      return PTR_ZERO;
    end else begin
      return p + PTR_ONE;
    end
  endfunction

  logic [FIFO_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [FIFO_PTR-1:0]   wr_ptr_r;
  logic [FIFO_PTR-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      room_r;
  logic                  empty_r;
  logic                  full_r;
  logic                  afull_r;
  logic                  aempty_r;
  logic                  ovf_r;
  logic                  udf_r;

  logic                  rd_acc_s;
  logic                  wr_acc_s;
  logic                  ovf_set_s;
  logic                  udf_set_s;
  logic [CNT_W-1:0]      count_nxt_s;

  // Acceptance decisions and next-state occupancy.
  // A full FIFO still takes a write when a read frees a slot on the same edge;
  // an empty FIFO never bypasses write data to the read side.
  always_comb begin
    rd_acc_s    = fifo_if.fifo_rden && !empty_r;
    wr_acc_s    = fifo_if.fifo_wren && (!full_r || rd_acc_s);
    ovf_set_s   = fifo_if.fifo_wren && !wr_acc_s;
    udf_set_s   = fifo_if.fifo_rden && !rd_acc_s;
    count_nxt_s = count_r;
    if (wr_acc_s && !rd_acc_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (rd_acc_s && !wr_acc_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, occupancy, registered status flags and sticky error flags.
  // Flags come from next-state occupancy so they are exact right after the edge.
  always_ff @(posedge fifo_clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      room_r   <= CNT_DEPTH;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r  <= count_nxt_s;
      room_r   <= CNT_DEPTH - count_nxt_s;
      empty_r  <= (count_nxt_s == CNT_ZERO);
      full_r   <= (count_nxt_s == CNT_DEPTH);
      afull_r  <= (count_nxt_s >= CNT_AFULL);
      aempty_r <= (count_nxt_s <= CNT_AEMPT);
      // A new error event wins over a clear in the same cycle.
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (fifo_if.fifo_err_clr) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
      if (udf_set_s) begin
        udf_r <= 1'b1;
      end else if (fifo_if.fifo_err_clr) begin
        udf_r <= 1'b0;
      end else begin
        udf_r <= udf_r;
      end
    end
  end

  // Storage array: written only on accepted writes, intentionally never cleared.
  always_ff @(posedge fifo_clk) begin
    if (!rst && wr_acc_s) begin
      mem_r[wr_ptr_r] <= fifo_if.fifo_wrdata;
    end
  end

  assign fifo_if.fifo_full       = full_r;
  assign fifo_if.fifo_empty      = empty_r;
  assign fifo_if.fifo_afull      = afull_r;
  assign fifo_if.fifo_aempty     = aempty_r;
  assign fifo_if.fifo_data_avail = count_r;
  assign fifo_if.fifo_room_avail = room_r;
  assign fifo_if.fifo_ovf        = ovf_r;
  assign fifo_if.fifo_udf        = udf_r;

`ifdef SYNCH_FIFO_FWFT_EN
  // Head of queue is always presented; rden acts as the pop/acknowledge.
  assign fifo_if.fifo_rddata  = mem_r[rd_ptr_r];
  assign fifo_if.fifo_rdvalid = !empty_r;
`else
  logic [FIFO_WIDTH-1:0] rddata_r;
  logic                  rdvalid_r;

  // Registered read port: data captured on the accepting edge, held otherwise.
  always_ff @(posedge fifo_clk) begin
    if (rst) begin
      rddata_r  <= {FIFO_WIDTH{1'b0}};
      rdvalid_r <= 1'b0;
    end else begin
      rdvalid_r <= rd_acc_s;
      if (rd_acc_s) begin
        rddata_r <= mem_r[rd_ptr_r];
      end else begin
        rddata_r <= rddata_r;
      end
    end
  end

  assign fifo_if.fifo_rddata  = rddata_r;
  assign fifo_if.fifo_rdvalid = rdvalid_r;
`endif
endmodule

// File: tb/tb_synch_fifo_gen2.sv
// tb_synch_fifo_gen2
// Directed self-checking bench: a 16-deep 32-bit instance and a 5-deep 8-bit
// instance sharing clock and reset. Read-side expectations follow the build
// option SYNCH_FIFO_FWFT_EN.
module tb_synch_fifo_gen2;
  logic fifo_clk = 1'b0;
  logic rst      = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  synch_fifo_gen2_if #(.FIFO_WIDTH(32), .FIFO_DEPTH(16)) if_a ();
  synch_fifo_gen2_if #(.FIFO_WIDTH(8),  .FIFO_DEPTH(5))  if_b ();

  synch_fifo_gen2 #(.FIFO_WIDTH(32), .FIFO_DEPTH(16), .AFULL_LVL(14), .AEMPTY_LVL(2))
    u_dut_a (.fifo_clk(fifo_clk), .rst(rst), .fifo_if(if_a));
  synch_fifo_gen2 #(.FIFO_WIDTH(8), .FIFO_DEPTH(5), .AFULL_LVL(4), .AEMPTY_LVL(1))
    u_dut_b (.fifo_clk(fifo_clk), .rst(rst), .fifo_if(if_b));

  always #5 fifo_clk = ~fifo_clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge fifo_clk);
    #1;
  endtask

  task automatic drive_a(input logic wr, input logic [31:0] wd, input logic rd, input logic clr);
    if_a.fifo_wren    = wr;
    if_a.fifo_wrdata  = wd;
    if_a.fifo_rden    = rd;
    if_a.fifo_err_clr = clr;
  endtask

  // Checks the full reset signature of instance A.
  task automatic chk_reset_a(input string tag);
    chk_eq({tag, "_empty"},  32'(if_a.fifo_empty), 32'd1);
    chk_eq({tag, "_aempty"}, 32'(if_a.fifo_aempty), 32'd1);
    chk_eq({tag, "_full"},   32'(if_a.fifo_full), 32'd0);
    chk_eq({tag, "_afull"},  32'(if_a.fifo_afull), 32'd0);
    chk_eq({tag, "_avail"},  32'(if_a.fifo_data_avail), 32'd0);
    chk_eq({tag, "_room"},   32'(if_a.fifo_room_avail), 32'd16);
    chk_eq({tag, "_ovf"},    32'(if_a.fifo_ovf), 32'd0);
    chk_eq({tag, "_udf"},    32'(if_a.fifo_udf), 32'd0);
    chk_eq({tag, "_rdvalid"}, 32'(if_a.fifo_rdvalid), 32'd0);
`ifndef SYNCH_FIFO_FWFT_EN
    chk_eq({tag, "_rddata"}, if_a.fifo_rddata, 32'd0);
`endif
  endtask

  logic [7:0] q_b [$];
  logic       ovf_m;
  logic       wr_b;
  logic       rd_b;
  logic       racc;
  logic       wacc;
  logic [7:0] wd_b;
  logic [7:0] popped;

  // One cycle of instance B against the queue model (state sampled pre-edge).
  task automatic cycle_b(input logic wr, input logic [7:0] wd, input logic rd);
    racc = rd && (q_b.size() != 0);
    wacc = wr && ((q_b.size() < 5) || racc);
`ifdef SYNCH_FIFO_FWFT_EN
    if (q_b.size() != 0) chk_eq("b_head", 32'(if_b.fifo_rddata), 32'(q_b[0]));
`endif
    if_b.fifo_wren   = wr;
    if_b.fifo_wrdata = wd;
    if_b.fifo_rden   = rd;
    step();
    popped = 8'h00;
    if (racc) popped = q_b.pop_front();
    if (wacc) q_b.push_back(wd);
    if (wr && !wacc) ovf_m = 1'b1;
    chk_eq("b_avail", 32'(if_b.fifo_data_avail), 32'(q_b.size()));
    chk_eq("b_full",  32'(if_b.fifo_full), 32'(q_b.size() == 5));
    chk_eq("b_ovf",   32'(if_b.fifo_ovf), 32'(ovf_m));
`ifndef SYNCH_FIFO_FWFT_EN
    chk_eq("b_rdvalid", 32'(if_b.fifo_rdvalid), 32'(racc));
    if (racc) chk_eq("b_rddata", 32'(if_b.fifo_rddata), 32'(popped));
`endif
  endtask

  initial begin
    drive_a(1'b0, 32'd0, 1'b0, 1'b0);
    if_b.fifo_wren = 1'b0; if_b.fifo_wrdata = 8'h00;
    if_b.fifo_rden = 1'b0; if_b.fifo_err_clr = 1'b0;
    ovf_m = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    chk_reset_a("rst");

    // Fill 16 entries back-to-back and watch thresholds.
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
      step();
      chk_eq("fill_avail",  32'(if_a.fifo_data_avail), 32'(i + 1));
      chk_eq("fill_room",   32'(if_a.fifo_room_avail), 32'(15 - i));
      chk_eq("fill_afull",  32'(if_a.fifo_afull), 32'((i + 1) >= 14));
      chk_eq("fill_aempty", 32'(if_a.fifo_aempty), 32'((i + 1) <= 2));
      chk_eq("fill_full",   32'(if_a.fifo_full), 32'((i + 1) == 16));
      chk_eq("fill_empty",  32'(if_a.fifo_empty), 32'd0);
`ifdef SYNCH_FIFO_FWFT_EN
      chk_eq("fwft_head", if_a.fifo_rddata, 32'hA000_0000);
      chk_eq("fwft_valid", 32'(if_a.fifo_rdvalid), 32'd1);
`endif
    end
    // 17th write is rejected.
    drive_a(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step();
    chk_eq("ovf_set",   32'(if_a.fifo_ovf), 32'd1);
    chk_eq("ovf_avail", 32'(if_a.fifo_data_avail), 32'd16);
    chk_eq("ovf_full",  32'(if_a.fifo_full), 32'd1);

    // Drain 16 and verify order.
    for (int i = 0; i < 16; i++) begin
`ifdef SYNCH_FIFO_FWFT_EN
      chk_eq("drain_head", if_a.fifo_rddata, 32'hA000_0000 + 32'(i));
`endif
      drive_a(1'b0, 32'd0, 1'b1, 1'b0);
      step();
`ifndef SYNCH_FIFO_FWFT_EN
      chk_eq("drain_data",  if_a.fifo_rddata, 32'hA000_0000 + 32'(i));
      chk_eq("drain_valid", 32'(if_a.fifo_rdvalid), 32'd1);
`endif
      chk_eq("drain_avail", 32'(if_a.fifo_data_avail), 32'(15 - i));
    end
    chk_eq("drain_empty", 32'(if_a.fifo_empty), 32'd1);
    drive_a(1'b0, 32'd0, 1'b0, 1'b0);
    step();
`ifndef SYNCH_FIFO_FWFT_EN
    chk_eq("idle_valid", 32'(if_a.fifo_rdvalid), 32'd0);
    chk_eq("idle_hold",  if_a.fifo_rddata, 32'hA000_000F);
`endif
    drive_a(1'b0, 32'd0, 1'b0, 1'b1);
    step();
    chk_eq("ovf_clr", 32'(if_a.fifo_ovf), 32'd0);

    // Full FIFO: simultaneous read and write both accepted.
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
      step();
    end
`ifdef SYNCH_FIFO_FWFT_EN
    chk_eq("full_rw_head", if_a.fifo_rddata, 32'hB000_0000);
`endif
    drive_a(1'b1, 32'hC000_0000, 1'b1, 1'b0);
    step();
    chk_eq("full_rw_full",  32'(if_a.fifo_full), 32'd1);
    chk_eq("full_rw_ovf",   32'(if_a.fifo_ovf), 32'd0);
    chk_eq("full_rw_avail", 32'(if_a.fifo_data_avail), 32'd16);
`ifndef SYNCH_FIFO_FWFT_EN
    chk_eq("full_rw_data", if_a.fifo_rddata, 32'hB000_0000);
`endif
    for (int i = 0; i < 16; i++) begin
`ifdef SYNCH_FIFO_FWFT_EN
      chk_eq("full_rw_order", if_a.fifo_rddata,
             (i == 15) ? 32'hC000_0000 : 32'hB000_0000 + 32'(i + 1));
`endif
      drive_a(1'b0, 32'd0, 1'b1, 1'b0);
      step();
`ifndef SYNCH_FIFO_FWFT_EN
      chk_eq("full_rw_order", if_a.fifo_rddata,
             (i == 15) ? 32'hC000_0000 : 32'hB000_0000 + 32'(i + 1));
`endif
    end

    // Empty FIFO: simultaneous read and write -> read rejected.
    drive_a(1'b1, 32'hD000_0000, 1'b1, 1'b0);
    step();
    chk_eq("empty_rw_udf",   32'(if_a.fifo_udf), 32'd1);
    chk_eq("empty_rw_avail", 32'(if_a.fifo_data_avail), 32'd1);
    chk_eq("empty_rw_empty", 32'(if_a.fifo_empty), 32'd0);
`ifndef SYNCH_FIFO_FWFT_EN
    chk_eq("empty_rw_valid", 32'(if_a.fifo_rdvalid), 32'd0);
`else
    chk_eq("empty_rw_head", if_a.fifo_rddata, 32'hD000_0000);
`endif
    drive_a(1'b0, 32'd0, 1'b1, 1'b0);
    step();
`ifndef SYNCH_FIFO_FWFT_EN
    chk_eq("empty_rw_data", if_a.fifo_rddata, 32'hD000_0000);
`endif
    chk_eq("empty_rw_drain", 32'(if_a.fifo_empty), 32'd1);
    // Clear together with a new underflow: set wins.
    drive_a(1'b0, 32'd0, 1'b1, 1'b1);
    step();
    chk_eq("udf_set_wins", 32'(if_a.fifo_udf), 32'd1);
    drive_a(1'b0, 32'd0, 1'b0, 1'b1);
    step();
    chk_eq("udf_clr", 32'(if_a.fifo_udf), 32'd0);

    // Reset with 7 entries queued.
    for (int i = 0; i < 7; i++) begin
      drive_a(1'b1, 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
      step();
    end
    chk_eq("pre_rst_avail", 32'(if_a.fifo_data_avail), 32'd7);
    drive_a(1'b0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_a("mid_rst");
    drive_a(1'b1, 32'hF000_0001, 1'b0, 1'b0);
    step();
`ifdef SYNCH_FIFO_FWFT_EN
    chk_eq("post_rst_head", if_a.fifo_rddata, 32'hF000_0001);
`endif
    drive_a(1'b0, 32'd0, 1'b1, 1'b0);
    step();
`ifndef SYNCH_FIFO_FWFT_EN
    chk_eq("post_rst_data", if_a.fifo_rddata, 32'hF000_0001);
`endif
    chk_eq("post_rst_empty", 32'(if_a.fifo_empty), 32'd1);
    drive_a(1'b0, 32'd0, 1'b0, 1'b0);

    // Depth 5: fill past full, then sustained read+write to wrap pointers.
    for (int k = 0; k < 12; k++) begin
      wr_b = 1'b1;
      rd_b = (k >= 6);
      wd_b = 8'h10 + 8'(k);
      cycle_b(wr_b, wd_b, rd_b);
    end
    for (int k = 0; k < 6; k++) begin
      cycle_b(1'b0, 8'h00, 1'b1);
    end
    chk_eq("b_empty", 32'(if_b.fifo_empty), 32'd1);
    chk_eq("b_udf",   32'(if_b.fifo_udf), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
